// File: rtl/nonrestoring_div_pkg.sv
// Shared widths, FSM encoding and quotient range limits for the sequential
// signed non-restoring divider (same W as the Booth multiplier it inverts).
package nonrestoring_div_pkg;

  localparam int W     = 8;
  localparam int CNT_W = $clog2(W) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // Largest positive quotient and largest negative quotient magnitude.
  localparam logic [W-1:0] Q_POS_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] Q_NEG_MAG = {1'b1, {(W-1){1'b0}}};

  function automatic logic [W-1:0] cond_neg(input logic neg, input logic [W-1:0] v);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/nonrestoring_div_if.sv
// Request/result bundle of the divider; master drives operands, slave returns results.
interface nonrestoring_div_if;
  import nonrestoring_div_pkg::*;

  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );

endinterface

// File: rtl/nr_div_step.sv
// One non-restoring iteration: shift {P,Q} left, add or subtract the divisor
// depending on the old sign of P, and shift in the new quotient bit.
module nr_div_step
  import nonrestoring_div_pkg::*;
(
  input  logic [W:0]   p_i,
  input  logic [W-1:0] q_i,
  input  logic [W-1:0] d_i,
  output logic [W:0]   p_o,
  output logic [W-1:0] q_o
);

  logic [W:0] p_sh;
  logic [W:0] d_ext;

  always_comb begin
    // P stays within [-D, D), so dropping its top bit on the shift is lossless.
    p_sh  = {p_i[W-1:0], q_i[W-1]};
    d_ext = {1'b0, d_i};
    p_o   = p_i[W] ? (p_sh + d_ext) : (p_sh - d_ext);
    q_o   = {q_i[W-2:0], ~p_o[W]};
  end

endmodule

// File: rtl/nonrestoring_div.sv
// Sequential signed 2W/W divider: sign/magnitude pre-processing, W iteration
// cycles, then one fix-up cycle applying signs, range check and flag outputs.
module nonrestoring_div
  import nonrestoring_div_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  nonrestoring_div_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W:0]       p_q, p_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic [W-1:0]     dvd_lo_q, dvd_lo_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic             ovu_q, ovu_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [W-1:0]     quotient_q, quotient_d;
  logic [W-1:0]     remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             overflow_q, overflow_d;

  logic [2*W-1:0]   dvd_abs;
  logic [W-1:0]     dvs_abs;
  logic             dvs_zero;
  logic [W:0]       p_step;
  logic [W-1:0]     acc_step;
  logic [W-1:0]     rem_mag;
  logic             ovs;

  nr_div_step u_step (
    .p_i (p_q),
    .q_i (acc_q),
    .d_i (dvs_q),
    .p_o (p_step),
    .q_o (acc_step)
  );

  always_comb begin
    dvd_abs  = bus.dividend[2*W-1] ? -bus.dividend : bus.dividend;
    dvs_abs  = bus.divisor[W-1] ? -bus.divisor : bus.divisor;
    dvs_zero = (bus.divisor == '0);
    // Final restore step; the corrected remainder is below D so W bits suffice.
    rem_mag  = p_q[W] ? (p_q[W-1:0] + dvs_q) : p_q[W-1:0];
    ovs      = neg_quo_q ? (acc_q > Q_NEG_MAG) : (acc_q > Q_POS_MAX);
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    p_d           = p_q;
    acc_d         = acc_q;
    dvs_d         = dvs_q;
    dvd_lo_d      = dvd_lo_q;
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    dz_d          = dz_q;
    ovu_d         = ovu_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    overflow_d    = overflow_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_CALC;
          cnt_d     = '0;
          p_d       = {1'b0, dvd_abs[2*W-1:W]};
          acc_d     = dvd_abs[W-1:0];
          dvs_d     = dvs_abs;
          dvd_lo_d  = bus.dividend[W-1:0];
          neg_quo_d = bus.dividend[2*W-1] ^ bus.divisor[W-1];
          neg_rem_d = bus.dividend[2*W-1];
          dz_d      = dvs_zero;
          // A high half at or above |D| can only yield a quotient wider than W bits.
          ovu_d     = (dvd_abs[2*W-1:W] >= dvs_abs) & ~dvs_zero;
          busy_d    = 1'b1;
        end
      end

      S_CALC: begin
        p_d   = p_step;
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W - 1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (dz_q) begin
          quotient_d    = '1;
          remainder_d   = dvd_lo_q;
          div_by_zero_d = 1'b1;
          overflow_d    = 1'b0;
        end else if (ovu_q || ovs) begin
          quotient_d    = '0;
          remainder_d   = '0;
          div_by_zero_d = 1'b0;
          overflow_d    = 1'b1;
        end else begin
          quotient_d    = cond_neg(neg_quo_q, acc_q);
          remainder_d   = cond_neg(neg_rem_q, rem_mag);
          div_by_zero_d = 1'b0;
          overflow_d    = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      p_q           <= '0;
      acc_q         <= '0;
      dvs_q         <= '0;
      dvd_lo_q      <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      dz_q          <= 1'b0;
      ovu_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      p_q           <= p_d;
      acc_q         <= acc_d;
      dvs_q         <= dvs_d;
      dvd_lo_q      <= dvd_lo_d;
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
      dz_q          <= dz_d;
      ovu_q         <= ovu_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      overflow_q    <= overflow_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = div_by_zero_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_nonrestoring_div.sv
// Scoreboard bench for nonrestoring_div: expected results are queued at issue
// and compared when done pulses, together with latency and busy shape.
module tb_nonrestoring_div;
  import nonrestoring_div_pkg::*;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ovf;
  } res_t;

  typedef struct packed {
    logic [2*W-1:0] dvd;
    logic [W-1:0]   dvs;
    res_t           exp;
  } vec_t;

  localparam int LAT = W + 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  res_t sb[$];

  nonrestoring_div_if bus ();

  nonrestoring_div dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [2*W-1:0] d, input logic [W-1:0] s);
    int   a, b, qf, rf;
    res_t r;
    a = int'($signed(d));
    b = int'($signed(s));
    r = '0;
    if (b == 0) begin
      r.q  = '1;
      r.r  = d[W-1:0];
      r.dz = 1'b1;
    end else begin
      qf = a / b;
      rf = a % b;
      if (qf > (2 ** (W - 1)) - 1 || qf < -(2 ** (W - 1))) begin
        r.ovf = 1'b1;
      end else begin
        r.q = W'(qf);
        r.r = W'(rf);
      end
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic [2*W-1:0] d, input logic [W-1:0] s,
                              input logic [W-1:0] q, input logic [W-1:0] r,
                              input logic dz, input logic ovf);
    vec_t v;
    v.dvd     = d;
    v.dvs     = s;
    v.exp.q   = q;
    v.exp.r   = r;
    v.exp.dz  = dz;
    v.exp.ovf = ovf;
    return v;
  endfunction

  // Called at a negedge: drives a request and queues its expected result.
  task automatic issue(input logic [2*W-1:0] d, input logic [W-1:0] s, input res_t e);
    bus.start    = 1'b1;
    bus.dividend = d;
    bus.divisor  = s;
    sb.push_back(e);
  endtask

  // mode 0: drop start after accept; 1: hold start through done; 2: pulse start while busy.
  task automatic wait_done(input int mode, input logic [2*W-1:0] nd, input logic [W-1:0] ns,
                           output int lat, output int berr, output res_t obs);
    int k;
    @(posedge clk);
    @(negedge clk);
    k    = 0;
    berr = 0;
    while (k < 40) begin
      bus.start    = (mode == 1) || (mode == 2 && k < 6);
      bus.dividend = nd;
      bus.divisor  = ns;
      if (bus.done === 1'b1) break;
      if (bus.busy !== 1'b1) berr++;
      @(negedge clk);
      k++;
    end
    lat = k;
    if (bus.busy !== 1'b0) berr++;
    obs.q   = bus.quotient;
    obs.r   = bus.remainder;
    obs.dz  = bus.div_by_zero;
    obs.ovf = bus.overflow;
  endtask

  task automatic test_reset();
    logic [2*W+3:0] outs;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    outs = {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, want 0", outs);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_table(input string name, input vec_t v[$]);
    int   lat, berr;
    res_t obs, e;
    foreach (v[i]) begin
      issue(v[i].dvd, v[i].dvs, v[i].exp);
      wait_done(0, 16'($urandom), 8'($urandom), lat, berr, obs);
      e = sb.pop_front();
      checks += 3;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s_result[%0d] %h/%h: got q=%h r=%h dz=%b ovf=%b, want q=%h r=%h dz=%b ovf=%b",
                 name, i, v[i].dvd, v[i].dvs, obs.q, obs.r, obs.dz, obs.ovf, e.q, e.r, e.dz, e.ovf);
      end
      if (lat !== LAT) begin
        errors++;
        $display("FAIL %s_latency[%0d]: got %0d cycles, want %0d", name, i, lat, LAT);
      end
      if (berr !== 0) begin
        errors++;
        $display("FAIL %s_busy_shape[%0d]: got %0d bad busy cycles, want 0", name, i, berr);
      end
    end
  endtask

  task automatic test_basic();
    vec_t v[$];
    v.push_back(mk(16'd42,   8'd6,   8'h07, 8'h00, 1'b0, 1'b0));
    v.push_back(mk(16'hD8A0, 8'h54,  8'h88, 8'h00, 1'b0, 1'b0));
    v.push_back(mk(16'h1356, 8'hC9,  8'hA6, 8'h00, 1'b0, 1'b0));
    v.push_back(mk(16'hFF9C, 8'h07,  8'hF2, 8'hFE, 1'b0, 1'b0));
    v.push_back(mk(16'h0064, 8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0));
    run_table("basic", v);
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: got done=%b busy=%b, want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_range();
    vec_t v[$];
    v.push_back(mk(16'hFF00, 8'h02, 8'h80, 8'h00, 1'b0, 1'b0));
    v.push_back(mk(16'h0100, 8'h02, 8'h00, 8'h00, 1'b0, 1'b1));
    v.push_back(mk(16'h4000, 8'h02, 8'h00, 8'h00, 1'b0, 1'b1));
    v.push_back(mk(16'h8000, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1));
    v.push_back(mk(16'hC080, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b0));
    v.push_back(mk(16'hC000, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1));
    v.push_back(mk(16'h007F, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0));
    run_table("range", v);
  endtask

  task automatic test_back_to_back();
    int   lat, berr;
    res_t obs, e;
    issue(16'd100, 8'd0, res_t'({8'hFF, 8'h64, 1'b1, 1'b0}));
    wait_done(1, 16'h03E8, 8'h0B, lat, berr, obs);
    e = sb.pop_front();
    checks += 2;
    if (obs !== e) begin
      errors++;
      $display("FAIL div_zero_result: got q=%h r=%h dz=%b ovf=%b, want q=%h r=%h dz=%b ovf=%b",
               obs.q, obs.r, obs.dz, obs.ovf, e.q, e.r, e.dz, e.ovf);
    end
    if (lat !== LAT) begin
      errors++;
      $display("FAIL div_zero_latency: got %0d cycles, want %0d", lat, LAT);
    end
    // start is still high in the done cycle, so the next edge accepts 1000/11.
    sb.push_back(res_t'({8'h5A, 8'h0A, 1'b0, 1'b0}));
    wait_done(0, 16'($urandom), 8'($urandom), lat, berr, obs);
    e = sb.pop_front();
    checks += 3;
    if (obs !== e) begin
      errors++;
      $display("FAIL b2b_result: got q=%h r=%h dz=%b ovf=%b, want q=%h r=%h dz=%b ovf=%b",
               obs.q, obs.r, obs.dz, obs.ovf, e.q, e.r, e.dz, e.ovf);
    end
    if (lat !== LAT) begin
      errors++;
      $display("FAIL b2b_latency: got %0d cycles, want %0d", lat, LAT);
    end
    if (berr !== 0) begin
      errors++;
      $display("FAIL b2b_busy_shape: got %0d bad busy cycles, want 0", berr);
    end
  endtask

  task automatic test_abort();
    logic [2*W+3:0] outs;
    int             dones;
    res_t           dropped;
    issue(16'd1000, 8'd7, model(16'd1000, 8'd7));
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    outs = {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got %h, want 0", outs);
    end
    rst_n   = 1'b1;
    dropped = sb.pop_front();
    dones   = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d active cycles after abort (q=%h dropped), want 0",
               dones, dropped.q);
    end
  endtask

  task automatic test_busy_ignore();
    int   lat, berr, extra;
    res_t obs, e;
    issue(16'h0BB8, 8'h19, res_t'({8'h78, 8'h00, 1'b0, 1'b0}));
    wait_done(2, 16'h0064, 8'h03, lat, berr, obs);
    e = sb.pop_front();
    checks += 3;
    if (obs !== e) begin
      errors++;
      $display("FAIL ignore_result: got q=%h r=%h dz=%b ovf=%b, want q=%h r=%h dz=%b ovf=%b",
               obs.q, obs.r, obs.dz, obs.ovf, e.q, e.r, e.dz, e.ovf);
    end
    if (lat !== LAT) begin
      errors++;
      $display("FAIL ignore_latency: got %0d cycles, want %0d", lat, LAT);
    end
    if (berr !== 0) begin
      errors++;
      $display("FAIL ignore_busy_shape: got %0d bad busy cycles, want 0", berr);
    end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ignore_no_queue: got %0d active cycles, want 0", extra);
    end
  endtask

  task automatic test_random();
    vec_t           v[$];
    logic [2*W-1:0] d;
    logic [W-1:0]   s;
    for (int i = 0; i < 24; i++) begin
      d = 16'($urandom);
      d = 16'($signed(d) >>> $urandom_range(0, 9));
      s = 8'($urandom);
      v.push_back(mk(d, s, '0, '0, 1'b0, 1'b0));
      v[i].exp = model(d, s);
    end
    run_table("random", v);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_range();
    test_back_to_back();
    test_abort();
    test_busy_ignore();
    test_random();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
